// File: rtl/wptr_full_gen.sv
// Write-side pointer and full-flag generator for the async CDC FIFO: binary/Gray write pointer plus registered full.
// Optional almost-full flag enabled by defining WAFULL_EN; otherwise wafull is tied low.
`ifndef WPTR_WIDTH
`define WPTR_WIDTH 8
`endif

module wptr_full_gen #(
  parameter int PTR_WIDTH    = `WPTR_WIDTH,
  parameter int AFULL_MARGIN = 4
) (
  input  logic                 wclk,
  input  logic                 wrst,
  input  logic                 winc,
  input  logic [PTR_WIDTH-1:0] rptr_gray_sync,
  output logic [PTR_WIDTH-2:0] waddr,
  output logic [PTR_WIDTH-1:0] wptr_bin,
  output logic [PTR_WIDTH-1:0] wptr_gray,
  output logic                 wfull,
  output logic                 wafull
);

  logic                 accept;
  logic [PTR_WIDTH-1:0] bin_next;
  logic [PTR_WIDTH-1:0] gray_next;
  logic [PTR_WIDTH-1:0] full_cmp;
  logic                 full_next;

  // Acceptance uses the registered full flag, so a write in the cycle the read side frees space is still dropped.
  always_comb begin
    accept    = winc & ~wfull;
    bin_next  = wptr_bin + {{(PTR_WIDTH-1){1'b0}}, accept};
    gray_next = (bin_next >> 1) ^ bin_next;
    full_cmp  = {~rptr_gray_sync[PTR_WIDTH-1:PTR_WIDTH-2], rptr_gray_sync[PTR_WIDTH-3:0]};
    full_next = (gray_next == full_cmp);
  end

  assign waddr = wptr_bin[PTR_WIDTH-2:0];

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wptr_bin  <= '0;
      wptr_gray <= '0;
      wfull     <= 1'b0;
    end else begin
      wptr_bin  <= bin_next;
      wptr_gray <= gray_next;
      wfull     <= full_next;
    end
  end

`ifdef WAFULL_EN
  localparam logic [PTR_WIDTH-1:0] AFULL_LEVEL = PTR_WIDTH'(2**(PTR_WIDTH-1) - AFULL_MARGIN);

  logic [PTR_WIDTH-1:0] rbin;
  logic [PTR_WIDTH-1:0] occ_next;

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin = '0;
    for (int i = 0; i < PTR_WIDTH; i++) begin
      rbin[i] = ^(rptr_gray_sync >> i);
    end
    occ_next = bin_next - rbin;
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wafull <= 1'b0;
    end else begin
      wafull <= (occ_next >= AFULL_LEVEL) | full_next;
    end
  end
`else
  assign wafull = 1'b0;
`endif

endmodule

// File: tb/tb_wptr_full_gen.sv
// Directed self-checking bench for wptr_full_gen (PTR_WIDTH=8, AFULL_MARGIN=4); wafull expectations follow WAFULL_EN.
module tb_wptr_full_gen;

  logic       wclk;
  logic       wrst;
  logic       winc;
  logic [7:0] rptr_gray_sync;
  logic [6:0] waddr;
  logic [7:0] wptr_bin;
  logic [7:0] wptr_gray;
  logic       wfull;
  logic       wafull;

  int total;
  int bad;

`ifdef WAFULL_EN
  localparam bit AFULL_ON = 1'b1;
`else
  localparam bit AFULL_ON = 1'b0;
`endif

  wptr_full_gen #(.PTR_WIDTH(8), .AFULL_MARGIN(4)) dut (
    .wclk           (wclk),
    .wrst           (wrst),
    .winc           (winc),
    .rptr_gray_sync (rptr_gray_sync),
    .waddr          (waddr),
    .wptr_bin       (wptr_bin),
    .wptr_gray      (wptr_gray),
    .wfull          (wfull),
    .wafull         (wafull)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  function automatic logic [7:0] to_gray(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  // Drive inputs, then sample 1 time unit after the rising edge.
  task automatic applyStimulus(input logic rst, input logic inc, input logic [7:0] rptr);
    wrst           = rst;
    winc           = inc;
    rptr_gray_sync = rptr;
    @(posedge wclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [7:0] bin, input logic [7:0] gray,
                          input logic full, input logic afull);
    checkOutput({tag, " wptr_bin"}, 32'(wptr_bin), 32'(bin));
    checkOutput({tag, " wptr_gray"}, 32'(wptr_gray), 32'(gray));
    checkOutput({tag, " waddr"}, 32'(waddr), 32'(bin[6:0]));
    checkOutput({tag, " wfull"}, 32'(wfull), 32'(full));
    checkOutput({tag, " wafull"}, 32'(wafull), 32'(afull));
  endtask

  initial begin
    logic [7:0] exp_bin;
    logic [7:0] prev_gray;
    logic [7:0] rd_bin;
    total = 0;
    bad   = 0;
    wrst = 1'b1;
    winc = 1'b0;
    rptr_gray_sync = 8'h00;

    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkAll("reset", 8'h00, 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 50; i++) applyStimulus(1'b0, 1'b1, 8'h00);
    checkAll("fifty_writes", 8'h32, 8'h2B, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b1, 8'h00);
    checkAll("reset_midstream", 8'h00, 8'h00, 1'b0, 1'b0);

    for (int i = 1; i <= 128; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h00);
      if (i == 123) checkOutput("afull_after_123", 32'(wafull), 32'(1'b0));
      if (i == 124) checkOutput("afull_after_124", 32'(wafull), 32'(AFULL_ON));
      if (i == 127) checkAll("fill_127", 8'h7F, 8'h40, 1'b0, AFULL_ON);
    end
    checkAll("fill_128", 8'h80, 8'hC0, 1'b1, AFULL_ON);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h00);
      checkAll("overflow_block", 8'h80, 8'hC0, 1'b1, AFULL_ON);
    end

    // Write coincides with the read pointer advancing: still dropped, full clears next edge.
    applyStimulus(1'b0, 1'b1, 8'h01);
    checkAll("release", 8'h80, 8'hC0, 1'b0, AFULL_ON);

    applyStimulus(1'b0, 1'b1, 8'h01);
    checkAll("refill", 8'h81, 8'hC1, 1'b1, AFULL_ON);

    applyStimulus(1'b1, 1'b0, 8'h00);
    checkAll("reset_before_wrap", 8'h00, 8'h00, 1'b0, 1'b0);

    exp_bin   = 8'h00;
    prev_gray = 8'h00;
    for (int i = 0; i < 300; i++) begin
      rd_bin = (exp_bin >= 8'd3) ? exp_bin - 8'd3 : 8'h00;
      applyStimulus(1'b0, 1'b1, to_gray(rd_bin));
      exp_bin = exp_bin + 8'd1;
      checkOutput("wrap wptr_bin", 32'(wptr_bin), 32'(exp_bin));
      checkOutput("wrap wptr_gray", 32'(wptr_gray), 32'(to_gray(exp_bin)));
      checkOutput("wrap gray_hamming_le1", 32'($countones(wptr_gray ^ prev_gray) <= 1), 32'd1);
      checkOutput("wrap wfull", 32'(wfull), 32'(1'b0));
      checkOutput("wrap wafull", 32'(wafull), 32'(1'b0));
      if (exp_bin == 8'h00) checkOutput("wrap gray_before_zero", 32'(prev_gray), 32'h80);
      prev_gray = wptr_gray;
    end
    checkAll("wrap_end", 8'h2C, 8'h3A, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
